// File: rtl/tpu_sequencer.sv
// tpu_sequencer: phase controller for the ROWxCOL systolic datapath.
// Per job it loads ROW weight rows, then streams num_vecs activation vectors
// from the unified buffer. Result-valid timing comes from an LAT-deep shift
// register fed by a_valid, and done pulses once the last result has appeared.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   start, abort         job request (IDLE only) / synchronous cancel
//   num_vecs             vector count, latched when start is accepted
//   busy, done           state != IDLE / one-cycle completion pulse
//   mem_re, mem_addr     buffer read request and address (0 when idle)
//   load, a_valid        weight-load strobe / activation valid on buffer output
//   out_valid, out_idx   result valid at array bottom and its vector index
module tpu_sequencer #(
    parameter int ROW        = 4,
    parameter int COL        = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int W_BASE     = 0,
    parameter int A_BASE     = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] num_vecs,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_re,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  load,
    output logic                  a_valid,
    output logic                  out_valid,
    output logic [ADDR_WIDTH-1:0] out_idx
);
    localparam int LAT = ROW + COL - 1;
    localparam logic [ADDR_WIDTH-1:0] W_B    = ADDR_WIDTH'(W_BASE);
    localparam logic [ADDR_WIDTH-1:0] A_B    = ADDR_WIDTH'(A_BASE);
    localparam logic [ADDR_WIDTH-1:0] ROW_M1 = ADDR_WIDTH'(ROW - 1);

    typedef enum logic [2:0] {IDLE, LOAD_W, STREAM, DRAIN, DONE} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_cnt, r_nv, r_idx, w_addr;
    logic                  r_load, r_av, w_re, w_accept, w_abort, w_last_w;
    logic [LAT-1:0]        r_sr;

    // abort beats a simultaneous start in IDLE
    assign w_accept = (r_state == IDLE) && start && !abort;
    assign w_abort  = (r_state != IDLE) && abort;
    assign w_last_w = (r_state == LOAD_W) && (r_cnt == ROW_M1);

    always_comb begin
        w_next = r_state;
        w_re   = 1'b0;
        w_addr = '0;
        case (r_state)
            IDLE:    w_next = w_accept ? LOAD_W : IDLE;
            LOAD_W: begin
                w_re   = 1'b1;
                w_addr = W_B + r_cnt;
                if (r_cnt == ROW_M1) w_next = (r_nv != '0) ? STREAM : DONE;
            end
            STREAM: begin
                w_re   = 1'b1;
                w_addr = A_B + r_cnt;
                if (r_cnt == r_nv - 1'b1) w_next = DRAIN;
            end
            DRAIN:   w_next = (out_valid && r_idx == r_nv - 1'b1) ? DONE : DRAIN;
            default: w_next = IDLE;
        endcase
        if (w_abort) w_next = IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_nv    <= '0;
            r_idx   <= '0;
            r_load  <= 1'b0;
            r_av    <= 1'b0;
            r_sr    <= '0;
        end else begin
            r_state <= w_next;
            // strobes trail the issuing state by one cycle to match the buffer's read latency
            r_load  <= !w_abort && (r_state == LOAD_W);
            r_av    <= !w_abort && (r_state == STREAM);
            r_sr    <= w_abort ? '0 : {r_sr[LAT-2:0], r_av};
            r_cnt   <= (w_accept || w_last_w) ? '0 : w_re ? r_cnt + 1'b1 : r_cnt;
            r_nv    <= w_accept ? num_vecs : r_nv;
            r_idx   <= w_accept ? '0 : out_valid ? r_idx + 1'b1 : r_idx;
        end
    end

    assign busy      = r_state != IDLE;
    assign done      = r_state == DONE;
    assign mem_re    = w_re;
    assign mem_addr  = w_addr;
    assign load      = r_load;
    assign a_valid   = r_av;
    assign out_valid = r_sr[LAT-1];
    assign out_idx   = r_idx;
endmodule

// File: tb/tb_tpu_sequencer.sv
// tb_tpu_sequencer: directed bench for tpu_sequencer (default bases and a wrapping A_BASE=14 copy).
module tb_tpu_sequencer;
    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [3:0] num_vecs = '0;
    logic       busy, done, mem_re, load, a_valid, out_valid;
    logic [3:0] mem_addr, out_idx;
    logic       w_busy, w_done, w_mem_re, w_load, w_a_valid, w_out_valid;
    logic [3:0] w_mem_addr, w_out_idx;
    logic [13:0] tr [0:63];
    logic [13:0] tw [0:63];
    int n_pass = 0, n_total = 0;

    always #5 clk = ~clk;

    tpu_sequencer u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vecs(num_vecs),
        .busy(busy), .done(done), .mem_re(mem_re), .mem_addr(mem_addr), .load(load),
        .a_valid(a_valid), .out_valid(out_valid), .out_idx(out_idx)
    );

    tpu_sequencer #(.A_BASE(14)) u_wrap (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .num_vecs(num_vecs),
        .busy(w_busy), .done(w_done), .mem_re(w_mem_re), .mem_addr(w_mem_addr), .load(w_load),
        .a_valid(w_a_valid), .out_valid(w_out_valid), .out_idx(w_out_idx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // {busy,done,mem_re,load,a_valid,out_valid,mem_addr,out_idx} for a job accepted at cycle s
    function automatic logic [13:0] exp_at(input int c, input int s, input int nv, input int ab);
        int   t  = c - s - 1;
        int   dn = (nv > 0) ? 12 + nv : 4;
        logic bz = t >= 0 && t <= dn;
        logic dn_p = t == dn;
        logic re = t >= 0 && t <= 3 + nv;
        logic ld = t >= 1 && t <= 4;
        logic av = t >= 5 && t <= 4 + nv;
        logic ov = t >= 12 && t <= 11 + nv;
        logic [3:0] ad = !re ? 4'd0 : (t < 4) ? 4'(t) : 4'(ab + t - 4);
        logic [3:0] ix = ov ? 4'(t - 12) : (t > 11 + nv) ? 4'(nv) : 4'd0;
        return {bz, dn_p, re, ld, av, ov, ad, ix};
    endfunction

    function automatic logic [13:0] exp_mode(input int m, input int c, input int ab);
        case (m)
            1:       return (c <= 18) ? exp_at(c, 0, 4, ab) : exp_at(c, 18, 4, ab);
            2:       return exp_at(c, 0, 0, ab);
            3:       return (c <= 7) ? exp_at(c, 0, 4, ab) : exp_at(c, 9, 4, ab);
            4:       return exp_at(c, 1, 4, ab);
            default: return exp_at(c, 0, 4, ab);
        endcase
    endfunction

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // records both DUTs per cycle; inputs for cycle c are driven after sampling it
    task automatic run(input int m, input int n);
        for (int c = 0; c < n; c++) begin
            tr[c] = {busy, done, mem_re, load, a_valid, out_valid, mem_addr, out_idx};
            tw[c] = {w_busy, w_done, w_mem_re, w_load, w_a_valid, w_out_valid, w_mem_addr, w_out_idx};
            case (m)
                1:       start = 1'b1;
                3:       start = (c == 0 || c == 9);
                4:       start = (c == 0 || c == 1);
                default: start = (c == 0);
            endcase
            abort    = (m == 3 && c == 7) || (m == 4 && c == 0);
            num_vecs = !start ? 4'd9 : (m == 2) ? 4'd0 : 4'd4;
            @(posedge clk); #1;
        end
        start = 1'b0; abort = 1'b0;
    endtask

    task automatic verify(input string name, input int m, input int n);
        for (int c = 0; c < n; c++) begin
            check($sformatf("%s c%0d", name, c), 32'(tr[c]), 32'(exp_mode(m, c, 4)));
            check($sformatf("%s_wrap c%0d", name, c), 32'(tw[c]), 32'(exp_mode(m, c, 14)));
        end
    endtask

    initial begin
        do_reset();
        check("reset_outputs", 32'({busy, done, mem_re, load, a_valid, out_valid, mem_addr, out_idx}), 32'd0);

        run(0, 24);
        verify("nominal", 0, 24);
        check("nom_addr_c5", 32'(tr[5][7:4]), 32'd4);
        check("nom_done_c17", 32'(tr[17][12]), 32'd1);
        check("nom_idx_c16", 32'(tr[16][3:0]), 32'd3);
        check("wrap_addr_c7", 32'(tw[7][7:4]), 32'd0);
        check("wrap_addr_c8", 32'(tw[8][7:4]), 32'd1);

        do_reset();
        run(1, 37);
        verify("b2b", 1, 37);

        do_reset();
        run(2, 10);
        verify("zero", 2, 10);
        check("zero_done_c5", 32'(tr[5][12]), 32'd1);

        do_reset();
        run(3, 30);
        verify("abort", 3, 30);
        check("abort_busy_c8", 32'(tr[8][13]), 32'd0);

        do_reset();
        run(4, 24);
        verify("idle_abort", 4, 24);

        do_reset();
        run(0, 10);
        #3 rst = 1'b1;
        #1 check("async_rst", 32'({busy, done, mem_re, load, a_valid, out_valid, mem_addr, out_idx}), 32'd0);
        check("async_rst_wrap", 32'({w_busy, w_done, w_mem_re, w_load, w_a_valid, w_out_valid, w_mem_addr, w_out_idx}), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        run(0, 24);
        verify("post_rst", 0, 24);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
